// File: rtl/pxl_timing_ctrl.sv
// pxl_timing_ctrl: video timing generator for the 24-bit pixel bus.
// Ports: pxl_clk/pxl_rst_n; enable; src_data/valid/ready in; pxl_* syncs,
// data/valid out; no_pixels, underflow (sticky), frame_done (pulse).
module pxl_timing_ctrl #(
   parameter int H_SYNC   = 2,
   parameter int H_BP     = 2,
   parameter int H_ACTIVE = 4,
   parameter int H_FP     = 2,
   parameter int V_SYNC   = 1,
   parameter int V_BP     = 1,
   parameter int V_ACTIVE = 3,
   parameter int V_FP     = 1
) (
   input  logic        pxl_clk,
   input  logic        pxl_rst_n,
   input  logic        enable,
   input  logic [23:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic        pxl_vsync,
   output logic        pxl_hsync,
   output logic [23:0] pxl_data,
   output logic        pxl_valid,
   output logic [15:0] no_pixels,
   output logic        underflow,
   output logic        frame_done
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   // One extra bit so region bounds equal to the total still fit.
   localparam logic [HW:0] H_SE   = (HW+1)'(H_SYNC);
   localparam logic [HW:0] H_AS   = (HW+1)'(H_SYNC + H_BP);
   localparam logic [HW:0] H_AE   = (HW+1)'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [HW:0] H_AL   = (HW+1)'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [HW:0] H_LAST = (HW+1)'(H_TOTAL - 1);
   localparam logic [VW:0] V_SE   = (VW+1)'(V_SYNC);
   localparam logic [VW:0] V_AS   = (VW+1)'(V_SYNC + V_BP);
   localparam logic [VW:0] V_AE   = (VW+1)'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [VW:0] V_LAST = (VW+1)'(V_TOTAL - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [HW:0]   hx;
   logic [VW:0]   vx;
   logic [15:0]   line_cnt;
   logic [15:0]   line_base;
   logic [15:0]   line_nxt;
   logic          run;
   logic          h_end;
   logic          v_end;
   logic          hsync_c;
   logic          vsync_c;
   logic          h_act;
   logic          v_act;
   logic          slot;
   logic          xfer;

   assign hx      = {1'b0, h_cnt};
   assign vx      = {1'b0, v_cnt};
   assign run     = (state == RUN);
   assign h_end   = (hx == H_LAST);
   assign v_end   = (vx == V_LAST);
   assign hsync_c = run && (hx < H_SE);
   assign vsync_c = run && (vx < V_SE);
   assign h_act   = (hx >= H_AS) && (hx < H_AE);
   assign v_act   = (vx >= V_AS) && (vx < V_AE);
   assign slot    = run && h_act && v_act;
   assign xfer    = slot && src_valid;

   assign src_ready = slot;

   // Count restarts at the first cycle of every line.
   assign line_base = (h_cnt == '0) ? 16'd0 : line_cnt;
   assign line_nxt  = (xfer && (line_base != 16'hFFFF)) ?
                      line_base + 16'd1 : line_base;

   always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
      if (!pxl_rst_n) begin
         state     <= IDLE;
         h_cnt     <= '0;
         v_cnt     <= '0;
         underflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (enable) begin
                  state     <= RUN;
                  underflow <= 1'b0;
               end
            end
            RUN: begin
               if (h_end) begin
                  h_cnt <= '0;
                  if (v_end) begin
                     v_cnt <= '0;
                     if (!enable) state <= IDLE;
                  end else begin
                     v_cnt <= v_cnt + 1'b1;
                  end
               end else begin
                  h_cnt <= h_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (slot && !src_valid) underflow <= 1'b1;
      end
   end

   always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
      if (!pxl_rst_n) begin
         pxl_hsync  <= 1'b0;
         pxl_vsync  <= 1'b0;
         pxl_valid  <= 1'b0;
         pxl_data   <= '0;
         frame_done <= 1'b0;
         line_cnt   <= '0;
         no_pixels  <= '0;
      end else begin
         pxl_hsync  <= hsync_c;
         pxl_vsync  <= vsync_c;
         pxl_valid  <= xfer;
         pxl_data   <= xfer ? src_data : 24'd0;
         frame_done <= run && h_end && v_end;
         line_cnt   <= line_nxt;
         if (slot && (hx == H_AL)) no_pixels <= line_nxt;
      end
   end

endmodule

// File: tb/tb_pxl_timing_ctrl.sv
// tb_pxl_timing_ctrl: randomized + directed bench with a frame-position
// reference model feeding a per-cycle scoreboard.
module tb_pxl_timing_ctrl;

   localparam int HS = 2, HB = 2, HA = 4, HF = 2;
   localparam int VS = 1, VB = 1, VA = 3, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FT = HT * VT;

   logic        pxl_clk = 1'b0;
   logic        pxl_rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] src_data = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic        pxl_vsync;
   logic        pxl_hsync;
   logic [23:0] pxl_data;
   logic        pxl_valid;
   logic [15:0] no_pixels;
   logic        underflow;
   logic        frame_done;

   pxl_timing_ctrl #(
      .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
   ) dut (
      .pxl_clk(pxl_clk),
      .pxl_rst_n(pxl_rst_n),
      .enable(enable),
      .src_data(src_data),
      .src_valid(src_valid),
      .src_ready(src_ready),
      .pxl_vsync(pxl_vsync),
      .pxl_hsync(pxl_hsync),
      .pxl_data(pxl_data),
      .pxl_valid(pxl_valid),
      .no_pixels(no_pixels),
      .underflow(underflow),
      .frame_done(frame_done)
   );

   always #5 pxl_clk = ~pxl_clk;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        pv;
      logic        fd;
      logic        uf;
      logic        rdy;
      logic [23:0] d;
      logic [15:0] np;
   } exp_t;

   exp_t        expq[$];
   logic [23:0] pixq[$];
   int          vectors = 0;
   int          miscompares = 0;
   bit          inc_mode = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit in_slot(input bit r, input int p);
      int h, v;
      h = p % HT;
      v = p / HT;
      return r && h >= HS + HB && h < HS + HB + HA &&
             v >= VS + VB && v < VS + VB + VA;
   endfunction

   // Reference model: frame position as a single index, h/v derived.
   initial begin
      bit   m_run;
      int   m_pos, m_lc, m_np, h, v;
      bit   m_uf, sl, xf;
      exp_t e;
      m_run = 0; m_pos = 0; m_lc = 0; m_np = 0; m_uf = 0;
      forever begin
         @(posedge pxl_clk);
         e = '0;
         if (!pxl_rst_n) begin
            m_run = 0; m_pos = 0; m_lc = 0; m_np = 0; m_uf = 0;
            pixq.delete();
         end else begin
            h = m_pos % HT;
            v = m_pos / HT;
            sl = in_slot(m_run, m_pos);
            xf = sl && src_valid;
            e.hs = m_run && h < HS;
            e.vs = m_run && v < VS;
            e.pv = xf;
            e.d  = xf ? src_data : 24'd0;
            e.fd = m_run && m_pos == FT - 1;
            if (xf) pixq.push_back(src_data);
            if (h == 0) m_lc = 0;
            if (xf && m_lc < 65535) m_lc++;
            if (sl && h == HS + HB + HA - 1) m_np = m_lc;
            if (sl && !src_valid) m_uf = 1;
            if (!m_run) begin
               if (enable) begin
                  m_run = 1; m_pos = 0; m_uf = 0;
               end
            end else if (m_pos == FT - 1) begin
               m_pos = 0;
               m_run = enable;
            end else begin
               m_pos++;
            end
            e.np  = 16'(m_np);
            e.uf  = m_uf;
            e.rdy = in_slot(m_run, m_pos);
         end
         expq.push_back(e);
      end
   end

   // Monitor: compares every cycle's outputs against the model.
   initial begin
      exp_t        e;
      logic [23:0] p;
      forever begin
         @(negedge pxl_clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("hsync", int'(pxl_hsync), int'(e.hs));
            chk("vsync", int'(pxl_vsync), int'(e.vs));
            chk("valid", int'(pxl_valid), int'(e.pv));
            chk("data", int'(pxl_data), int'(e.d));
            chk("frame_done", int'(frame_done), int'(e.fd));
            chk("no_pixels", int'(no_pixels), int'(e.np));
            chk("underflow", int'(underflow), int'(e.uf));
            chk("src_ready", int'(src_ready), int'(e.rdy));
         end
         if (pxl_valid) begin
            if (pixq.size() == 0) begin
               chk("pix_unexpected", 1, 0);
            end else begin
               p = pixq.pop_front();
               chk("pix_order", int'(pxl_data), int'(p));
            end
         end
      end
   end

   task automatic step();
      @(negedge pxl_clk);
      #1;
      if (inc_mode && pxl_valid) src_data = src_data + 24'd1;
   endtask

   task automatic wait_fd(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_done && n < 200);
      if (!frame_done) chk("frame_done_timeout", 0, 1);
   endtask

   initial begin
      int n, c_hs, c_vs, c_pv, c_fd;
      repeat (3) step();
      chk("rst_hsync", int'(pxl_hsync), 0);
      chk("rst_ready", int'(src_ready), 0);
      chk("rst_np", int'(no_pixels), 0);
      pxl_rst_n = 1'b1;
      step();

      // Constant valid, incrementing data; blanking never handshakes.
      inc_mode = 1'b1;
      src_data = 24'd1;
      src_valid = 1'b1;
      enable = 1'b1;
      repeat (130) step();
      c_hs = 0; c_vs = 0; c_pv = 0; c_fd = 0;
      for (int i = 0; i < FT; i++) begin
         step();
         c_hs += int'(pxl_hsync);
         c_vs += int'(pxl_vsync);
         c_pv += int'(pxl_valid);
         c_fd += int'(frame_done);
      end
      chk("hsync_per_frame", c_hs, 12);
      chk("vsync_per_frame", c_vs, 10);
      chk("valid_per_frame", c_pv, 12);
      chk("fd_per_frame", c_fd, 1);
      chk("np_full", int'(no_pixels), 4);
      chk("uf_clean", int'(underflow), 0);

      // Miss the 2nd slot of the first active line.
      wait_fd(n);
      n = 0;
      while (!src_ready && n < 100) begin
         step();
         n++;
      end
      chk("ready_seen", int'(src_ready), 1);
      step();
      src_valid = 1'b0;
      step();
      src_valid = 1'b1;
      repeat (2) step();
      chk("np_after_miss", int'(no_pixels), 3);
      chk("uf_set", int'(underflow), 1);
      repeat (10) step();
      chk("np_next_line", int'(no_pixels), 4);
      chk("uf_sticky", int'(underflow), 1);

      // Drop enable mid-frame: frame completes, then idle.
      wait_fd(n);
      repeat (20) step();
      enable = 1'b0;
      wait_fd(n);
      chk("fd_after_drop", n, 40);
      c_hs = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         c_hs += int'(pxl_hsync) + int'(pxl_vsync) + int'(pxl_valid);
      end
      chk("idle_quiet", c_hs, 0);
      chk("uf_hold_idle", int'(underflow), 1);
      enable = 1'b1;
      repeat (3) step();
      chk("uf_cleared", int'(underflow), 0);

      // Asynchronous reset mid-frame.
      wait_fd(n);
      repeat (35) step();
      pxl_rst_n = 1'b0;
      #1;
      chk("arst_hsync", int'(pxl_hsync), 0);
      chk("arst_vsync", int'(pxl_vsync), 0);
      chk("arst_valid", int'(pxl_valid), 0);
      chk("arst_data", int'(pxl_data), 0);
      chk("arst_np", int'(no_pixels), 0);
      chk("arst_ready", int'(src_ready), 0);
      repeat (2) step();
      pxl_rst_n = 1'b1;
      wait_fd(n);
      chk("fd_after_rst", n, FT + 1);

      // Randomized traffic with occasional enable toggles.
      inc_mode = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         step();
         src_valid = ($urandom_range(0, 3) != 0);
         src_data = 24'($urandom);
         if ($urandom_range(0, 79) == 0) enable = ~enable;
         if ($urandom_range(0, 599) == 0) begin
            pxl_rst_n = 1'b0;
            step();
            pxl_rst_n = 1'b1;
         end
      end

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pxl_timing_ctrl.md
# pxl_timing_ctrl

Video timing controller that sequences the 24-bit pixel interface toward the DSI packetiser. It generates `pxl_hsync`, `pxl_vsync` and `pxl_valid` from programmable porch/sync/active parameters and pulls pixel data from an upstream source with a ready/valid handshake. It also reports per-line delivered pixel count, source underflow and end-of-frame. It sits between the frame/pattern source and the pixel-to-DSI bridge, in the pixel clock domain.

## Interface
- `H_SYNC`, 2, hsync width in pixel clocks
- `H_BP`, 2, horizontal back porch
- `H_ACTIVE`, 4, active pixels per line (≤ 65535)
- `H_FP`, 2, horizontal front porch
- `V_SYNC`, 1, vsync width in lines
- `V_BP`, 1, vertical back porch in lines
- `V_ACTIVE`, 3, active lines per frame
- `V_FP`, 1, vertical front porch in lines
- `pxl_clk`  in  1  pixel clock, all logic on rising edge
- `pxl_rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  level; start/continue frame generation
- `src_data`  in  24  upstream pixel (RGB888)
- `src_valid`  in  1  upstream pixel available
- `src_ready`  out  1  controller accepts `src_data` this cycle
- `pxl_vsync`  out  1  vertical sync, active high
- `pxl_hsync`  out  1  horizontal sync, active high
- `pxl_data`  out  24  pixel data, 0 when not valid
- `pxl_valid`  out  1  `pxl_data` qualifier
- `no_pixels`  out  16  pixels delivered in last completed active line
- `underflow`  out  1  sticky: source missed an active slot
- `frame_done`  out  1  one-cycle pulse after last cycle of a frame

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Counters `h_cnt` (0..H_TOTAL-1), `v_cnt` (0..V_TOTAL-1), widths $clog2 of totals.
- FSM states: IDLE, RUN.
  - IDLE: counters held at 0; on `enable`=1 → RUN; `underflow` cleared on this transition.
  - RUN: `h_cnt` increments every cycle, wraps to 0 at H_TOTAL-1 and `v_cnt` increments; `v_cnt` wraps to 0 at V_TOTAL-1. At the last frame cycle (h=H_TOTAL-1, v=V_TOTAL-1): if `enable`=0 → IDLE, else continue with next frame. Deasserting `enable` mid-frame never truncates a frame.
- Regions (current counters): hsync = h_cnt < H_SYNC; vsync = v_cnt < V_SYNC; h_act = H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACTIVE; v_act = V_SYNC+V_BP ≤ v_cnt < V_SYNC+V_BP+V_ACTIVE; slot = RUN & h_act & v_act.
- `src_ready` = slot (combinational from state/counters, independent of `src_valid`).
- Transfer = slot & `src_valid`: next cycle `pxl_valid`=1, `pxl_data`=`src_data`. Slot without `src_valid`: next cycle `pxl_valid`=0, `pxl_data`=0, `underflow` set; slot is not retried, timing never stalls.
- Line pixel counter: cleared at h_cnt=0, +1 per transfer; at the last active slot of an active line, `no_pixels` loads the final count (including that cycle's transfer). Saturates at 16'hFFFF.

## Timing
- Reset values: `pxl_vsync`, `pxl_hsync`, `pxl_valid`, `frame_done`, `underflow` = 0; `pxl_data`=0; `no_pixels`=0; state IDLE; counters 0. `src_ready`=0 during reset.
- `pxl_hsync`, `pxl_vsync`, `pxl_valid`, `pxl_data` are registered: value at cycle t+1 reflects counters/handshake at cycle t (1-cycle latency, all four aligned).
- First RUN cycle is the cycle after `enable` sampled high in IDLE; `pxl_hsync`/`pxl_vsync` rise one cycle later.
- `frame_done` asserted the cycle after h=H_TOTAL-1, v=V_TOTAL-1, for exactly one cycle.
- In IDLE all registered outputs return to 0 one cycle after entry; `no_pixels` and `underflow` hold.
- Reset mid-frame: all outputs to reset values immediately (async), restart only on `enable`.

## Test plan
- Defaults, `enable`=1, `src_valid`=1 constant → H_TOTAL=10, V_TOTAL=6; hsync high 2 of every 10 cycles; vsync high 10 cycles per 60; 12 `pxl_valid` cycles per frame in 3 bursts of 4; `no_pixels`=4; `frame_done` every 60 cycles; `underflow`=0.
- Incrementing `src_data` (0x000001 upward, advanced on transfer) → `pxl_data` sequence 1..12 per frame, one cycle after each `src_ready`&`src_valid`.
- `src_valid`=0 for the 2nd slot of line 1 → that output cycle `pxl_valid`=0, `pxl_data`=0; `underflow`=1 and stays; `no_pixels`=3 after that line, 4 after next.
- `enable` dropped at cycle 20 of a frame → frame completes to cycle 59, `frame_done` pulses, FSM IDLE, no further syncs; re-raise → new frame, `underflow` cleared.
- `pxl_rst_n` asserted at cycle 35 of a frame → all outputs 0 asynchronously, `no_pixels`=0; release with `enable`=1 → fresh frame from h=0, v=0.
- `src_valid`=1 during blanking → `src_ready` stays 0, no transfer, `pxl_valid` stays 0.
